// File: rtl/imem_load_pkg.sv
// imem_load_pkg: shared types and constants for the instruction-memory loader.
//   imem_load_state_t : loader FSM state encoding
//   WORD_SHIFT        : word index to byte address shift (4-byte words)
package imem_load_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StRun,
    StError
  } imem_load_state_t;

  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/imem_csum_acc.sv
// imem_csum_acc: modulo-2^WIDTH running sum of accepted instruction words.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the sum (takes priority over acc_en)
//   acc_en     : add data into the sum this cycle
//   data       : word to accumulate
//   sum        : current accumulated value
module imem_csum_acc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (acc_en) begin
      sum_d = sum_q + data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader and fetch-gate controller for instruction memory.
// Streams valid/ready words into consecutive word addresses, keeps the core held
// until the image is complete, issues a one-cycle flush, then releases the core.
// A start pulse in IDLE, RUN or ERROR begins a (re)load from word 0.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   start              : begin a load from word 0
//   ld_valid/ld_ready  : stream handshake; ld_data word, ld_last marks final word
//   imem_wr_en/_addr   : registered write strobe and byte address
//   imem_instr_in      : registered write data
//   imem_flush         : one-cycle NOP force after the image completes
//   core_hold          : stall PC/fetch (low only in RUN)
//   busy, done, error  : LOAD|FLUSH, RUN, ERROR status
//   words_loaded       : words accepted in the current or last load
// Optional feature macro IMEM_LOAD_CSUM_EN adds csum_expected (in) and csum (out);
// a last beat whose running sum differs from csum_expected goes to ERROR.
module imem_loader
  import imem_load_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [WIDTH-1:0]             ld_data,
  input  logic                         ld_last,
  output logic                         imem_wr_en,
  output logic [$clog2(SIZE)+1:0]      imem_wr_addr,
  output logic [WIDTH-1:0]             imem_instr_in,
  output logic                         imem_flush,
  output logic                         core_hold,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
`ifdef IMEM_LOAD_CSUM_EN
  input  logic [WIDTH-1:0]             csum_expected,
  output logic [WIDTH-1:0]             csum,
`endif
  output logic [$clog2(SIZE):0]        words_loaded
);

  localparam int unsigned LOGSIZE = $clog2(SIZE);

  imem_load_state_t    state_q, state_d;
  logic [LOGSIZE:0]    words_q, words_d;
  logic                wr_en_q, wr_en_d;
  logic [LOGSIZE+1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [LOGSIZE+1:0]  beat_addr;
  logic                accept;
  logic                csum_fail;

  assign ld_ready  = (state_q == StLoad);
  assign accept    = ld_valid & ld_ready;
  assign beat_addr = {2'b00, words_q[LOGSIZE-1:0]} << WORD_SHIFT;

`ifdef IMEM_LOAD_CSUM_EN
  logic             csum_clear;
  logic [WIDTH-1:0] csum_final;

  assign csum_clear = start & (state_q inside {StIdle, StRun, StError});
  // The sum register lags by one beat, so fold in the word being accepted now.
  assign csum_final = csum + ld_data;
  assign csum_fail  = (csum_final != csum_expected);

  imem_csum_acc #(
    .WIDTH (WIDTH)
  ) u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (csum_clear),
    .acc_en (accept),
    .data   (ld_data),
    .sum    (csum)
  );
`else
  assign csum_fail = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StIdle, StRun, StError: begin
        if (start) begin
          state_d = StLoad;
          words_d = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = beat_addr;
          wr_data_d = ld_data;
          words_d   = words_q + 1'b1;
          if (ld_last) begin
            state_d = csum_fail ? StError : StFlush;
          end else if (words_q == (LOGSIZE+1)'(SIZE - 1)) begin
            // Final slot written without ld_last: stop before any index >= SIZE.
            state_d = StError;
          end
        end
      end
      StFlush: state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      words_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign imem_wr_en    = wr_en_q;
  assign imem_wr_addr  = wr_addr_q;
  assign imem_instr_in = wr_data_q;
  assign imem_flush    = (state_q == StFlush);
  assign core_hold     = (state_q != StRun);
  assign busy          = (state_q == StLoad) || (state_q == StFlush);
  assign done          = (state_q == StRun);
  assign error         = (state_q == StError);
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (SIZE=8, WIDTH=32).
// Define IMEM_LOAD_CSUM_EN for both bench and RTL to include the checksum cases.
module tb_imem_loader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SIZE  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_data;
  logic             ld_last;
  logic             imem_wr_en;
  logic [4:0]       imem_wr_addr;
  logic [WIDTH-1:0] imem_instr_in;
  logic             imem_flush;
  logic             core_hold;
  logic             busy;
  logic             done;
  logic             error;
  logic [3:0]       words_loaded;
`ifdef IMEM_LOAD_CSUM_EN
  logic [WIDTH-1:0] csum_expected;
  logic [WIDTH-1:0] csum;
`endif

  int n_chk = 0;
  int n_err = 0;

  imem_loader #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .imem_wr_en    (imem_wr_en),
    .imem_wr_addr  (imem_wr_addr),
    .imem_instr_in (imem_instr_in),
    .imem_flush    (imem_flush),
    .core_hold     (core_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
`ifdef IMEM_LOAD_CSUM_EN
    .csum_expected (csum_expected),
    .csum          (csum),
`endif
    .words_loaded  (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [4];
  logic        gap_v [7];

  initial begin
    int idx;
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_8113;
    prog[3] = 32'h0000_006F;
    gap_v[0] = 1'b1; gap_v[1] = 1'b0; gap_v[2] = 1'b0; gap_v[3] = 1'b1;
    gap_v[4] = 1'b0; gap_v[5] = 1'b0; gap_v[6] = 1'b1;

    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
    csum_expected = '0;
`endif
    tick(); tick();
    // Reset state
    check_eq("rst_core_hold", 32'(core_hold), 32'd1);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
    check_eq("rst_wr_en", 32'(imem_wr_en), 32'd0);
    check_eq("rst_status", {29'd0, busy, done, error}, 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;

    // Basic 4-word load
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 3);
      tick();
      check_eq("basic_wr_en", 32'(imem_wr_en), 32'd1);
      check_eq("basic_addr", 32'(imem_wr_addr), 32'(i * 4));
      check_eq("basic_data", imem_instr_in, prog[i]);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("basic_flush", 32'(imem_flush), 32'd1);
    check_eq("basic_hold_in_flush", 32'(core_hold), 32'd1);
    tick();
    check_eq("basic_flush_gone", 32'(imem_flush), 32'd0);
    check_eq("basic_done", 32'(done), 32'd1);
    check_eq("basic_hold_released", 32'(core_hold), 32'd0);
    check_eq("basic_words", 32'(words_loaded), 32'd4);
    ld_valid = 1'b1; ld_data = 32'h5555_5555;
    tick();
    check_eq("run_ignores_valid", 32'(imem_wr_en), 32'd0);
    ld_valid = 1'b0;

    // Reload one word from RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("reload_hold", 32'(core_hold), 32'd1);
    check_eq("reload_not_done", 32'(done), 32'd0);
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("reload_addr", 32'(imem_wr_addr), 32'd0);
    check_eq("reload_data", imem_instr_in, 32'hDEAD_BEEF);
    check_eq("reload_hold_flush", 32'(core_hold), 32'd1);
    tick();
    check_eq("reload_done", 32'(done), 32'd1);
    check_eq("reload_hold_off", 32'(core_hold), 32'd0);

    // Gapped stream: 1,0,0,1,0,0,1 with last on the final valid beat
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      ld_valid = gap_v[k]; ld_data = 32'h100 + 32'(k); ld_last = (k == 6);
      tick();
      check_eq("gap_wr_en", 32'(imem_wr_en), 32'(gap_v[k]));
      if (gap_v[k]) begin
        check_eq("gap_addr", 32'(imem_wr_addr), 32'(idx * 4));
        check_eq("gap_data", imem_instr_in, 32'h100 + 32'(k));
        idx++;
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("gap_flush", 32'(imem_flush), 32'd1);
    tick();
    check_eq("gap_done", 32'(done), 32'd1);
    check_eq("gap_words", 32'(words_loaded), 32'd3);

    // Overflow: SIZE words without ld_last
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_data = 32'(i); ld_last = 1'b0;
      tick();
      check_eq("ovf_addr", 32'(imem_wr_addr), 32'(i * 4));
    end
    check_eq("ovf_error", 32'(error), 32'd1);
    check_eq("ovf_hold", 32'(core_hold), 32'd1);
    check_eq("ovf_ld_ready", 32'(ld_ready), 32'd0);
    check_eq("ovf_words", 32'(words_loaded), 32'd8);
    check_eq("ovf_no_flush", 32'(imem_flush), 32'd0);
    ld_data = 32'h99;
    tick();
    check_eq("ovf_no_write", 32'(imem_wr_en), 32'd0);
    check_eq("ovf_sticky", 32'(error), 32'd1);
    ld_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ovf_start_clears", 32'(error), 32'd0);
    check_eq("ovf_restart_ready", 32'(ld_ready), 32'd1);
    check_eq("ovf_restart_words", 32'(words_loaded), 32'd0);

    // Reset after 2 of 5 words
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA0 + 32'(i); ld_last = 1'b0;
      tick();
    end
    ld_data = 32'hA2;
    check_eq("abort_pre_wr_en", 32'(imem_wr_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_wr_en", 32'(imem_wr_en), 32'd0);
    check_eq("abort_words", 32'(words_loaded), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ld_ready", 32'(ld_ready), 32'd0);
    check_eq("abort_hold", 32'(core_hold), 32'd1);
    tick();
    check_eq("abort_still_no_write", 32'(imem_wr_en), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("abort_idle_no_write", 32'(imem_wr_en), 32'd0);
    ld_valid = 1'b0;

`ifdef IMEM_LOAD_CSUM_EN
    // Checksum mismatch then match
    for (int pass = 0; pass < 2; pass++) begin
      csum_expected = (pass == 0) ? 32'd7 : 32'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("csum_cleared", csum, 32'd0);
      for (int i = 1; i <= 3; i++) begin
        ld_valid = 1'b1; ld_data = 32'(i); ld_last = (i == 3);
        tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      check_eq("csum_sum", csum, 32'd6);
      if (pass == 0) begin
        check_eq("csum_bad_error", 32'(error), 32'd1);
        check_eq("csum_bad_no_flush", 32'(imem_flush), 32'd0);
        check_eq("csum_bad_hold", 32'(core_hold), 32'd1);
      end else begin
        check_eq("csum_ok_flush", 32'(imem_flush), 32'd1);
        tick();
        check_eq("csum_ok_done", 32'(done), 32'd1);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader and fetch-gate controller for the pipelined core's instruction memory. Accepts a valid/ready stream of instruction words, sequences them into the instruction memory write port at consecutive word addresses, and holds the core stalled until the image is complete. On completion it issues a one-cycle flush so the fetch register presents a NOP, then releases the core. A later `start` pulse can reload the memory at run time.

## Interface
- `WIDTH`, 32, bits per instruction word
- `SIZE`, 256, instruction memory depth in words; `LOGSIZE = $clog2(SIZE)` is a localparam
- `clk`  in  1  core clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  pulse; begins a load from word 0
- `ld_valid`  in  1  stream word valid
- `ld_ready`  out  1  loader accepts a word this cycle
- `ld_data`  in  WIDTH  instruction word
- `ld_last`  in  1  marks the final word of the image
- `imem_wr_en`  out  1  write strobe to instruction memory
- `imem_wr_addr`  out  LOGSIZE+2  byte address; bits [1:0] always 0
- `imem_instr_in`  out  WIDTH  write data
- `imem_flush`  out  1  forces instruction memory output to NOP
- `core_hold`  out  1  stalls PC/fetch while high
- `busy`  out  1  state is LOAD or FLUSH
- `done`  out  1  image loaded, core running
- `error`  out  1  overflow (or checksum mismatch, see Configuration)
- `words_loaded`  out  LOGSIZE+1  words accepted in the current or last load

## Operation
- States: IDLE, LOAD, FLUSH, RUN, ERROR.
- IDLE: `core_hold`=1, `ld_ready`=0. `start` → LOAD; clear `words_loaded`.
- LOAD: `ld_ready`=1. A beat is accepted when `ld_valid & ld_ready`. Each accepted beat writes word index `words_loaded` and increments the count.
  - Accepted beat with `ld_last`=1 → FLUSH.
  - Accepted beat at index SIZE-1 with `ld_last`=0 → ERROR. The write still occurs, so no index ≥ SIZE is ever written.
- FLUSH: `imem_flush`=1 for exactly one cycle, `core_hold`=1 → RUN.
- RUN: `core_hold`=0, `done`=1. `start` → LOAD with `core_hold` reasserted in the same cycle the state changes.
- ERROR: `core_hold`=1, `error`=1 (sticky). Only `start` (→ LOAD, clears `error`) or `reset` leave it.
- `start` is ignored in LOAD and FLUSH.
- `ld_valid` outside LOAD is ignored: no write, `ld_ready`=0.

## Timing
- Write port is registered. A beat accepted in cycle N produces `imem_wr_en`=1 with matching addr/data in cycle N+1. Addr = index×4.
- Last beat accepted in cycle N gives FLUSH in N+1, coincident with the final write. RUN and `done` follow in N+2.
- `start` in cycle N gives `ld_ready`=1 in N+1.
- Reset values: state IDLE, `core_hold`=1, all other outputs 0, `words_loaded`=0.
- Reset asserted mid-load aborts immediately with no further writes. Already-written memory words are not cleared.

## Configuration
- Macro: `IMEM_LOAD_CSUM_EN`.
- When defined:
  - Add input `csum_expected` [WIDTH-1:0] and output `csum` [WIDTH-1:0].
  - `csum` is the modulo-2^WIDTH sum of accepted words, cleared on `start`.
  - On the last beat, the final sum (including that word) is compared with `csum_expected`. Mismatch → ERROR instead of FLUSH, in cycle N+1, with `core_hold` kept high.
- When undefined: these ports do not exist and no comparison is made.

## Structure
- Package `imem_load_pkg` holds:
  - the `imem_load_state_t` enum (IDLE, LOAD, FLUSH, RUN, ERROR);
  - a byte-offset constant `WORD_SHIFT = 2`.
- Sub-module `imem_csum_acc` (clear, accumulate-enable, data → sum) is instantiated only under `IMEM_LOAD_CSUM_EN`.

## Test plan
- Reset, `start`, then 4 words 0x00000013, 0x00100093, 0x00208113, 0x0000006F with last on word 4:
  - `imem_wr_addr` sequence 0, 4, 8, 12;
  - one `imem_flush` pulse;
  - `done`=1 and `core_hold`=0 two cycles after the last beat.
- Gap stimulus: `ld_valid` toggled 1,0,0,1,… → writes occur only on valid cycles; addresses stay contiguous.
- SIZE=8, 8 words with no `ld_last`:
  - `error`=1 and `core_hold`=1;
  - highest address written is 28;
  - `start` clears `error`.
- Reset asserted after 2 of 5 words → `imem_wr_en` drops immediately, state IDLE, `words_loaded`=0.
- In RUN, `start` then a 1-word reload → `core_hold` high from the state change until RUN is re-entered; address 0 is rewritten.
- With `IMEM_LOAD_CSUM_EN`, words 1, 2, 3 and `csum_expected`=7 → ERROR and no flush; repeat with `csum_expected`=6 → RUN.
